// File: rtl/s_axis_rq_arbiter_pkg.sv
// Shared definitions for the requester-request (RQ) stream arbiters:
// TLP format codes, the tuser bit layout, the port limit and the arbiter
// state encoding.
package s_axis_rq_arbiter_pkg;

    // Upper bound on requesters sharing one RQ stream; grant ids are 2 bits.
    localparam int RQ_PORTS_MAX = 4;

    // fmt field (dword 0 bits 31:30) of a legacy TLP header: 3/4 DW, no data.
    localparam logic [1:0] FMT_NODATA = 2'b00;

    // tuser bit layout, carried through the arbiter untouched.
    typedef struct packed {
        logic disc;
        logic rsvd;
        logic ep;
        logic ecrc;
    } rq_tuser_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Round-robin successor of a port index, wrapping at num_ports.
    function automatic logic [1:0] rr_next(input logic [1:0] cur, input int num_ports);
        if (int'(cur) >= num_ports - 1) begin
            return 2'd0;
        end
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/s_axis_rq_arbiter_if.sv
// AXIS bundle between the TLP sources and the RQ adapter. The master side
// is the set of requesters plus the adapter's ready; the slave side is the
// arbiter that multiplexes them.
interface s_axis_rq_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [NUM_PORTS-1:0]            s_tvalid;
    logic [NUM_PORTS-1:0]            s_tready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep;
    logic [NUM_PORTS-1:0]            s_tlast;
    logic [NUM_PORTS*4-1:0]          s_tuser;

    logic                            m_axis_rq_tvalid;
    logic [3:0]                      m_axis_rq_tready;
    logic [DATA_WIDTH-1:0]           m_axis_rq_tdata;
    logic [KEEP_WIDTH-1:0]           m_axis_rq_tkeep;
    logic                            m_axis_rq_tlast;
    logic [3:0]                      m_axis_rq_tuser;

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_axis_rq_tready,
        input  s_tready, m_axis_rq_tvalid, m_axis_rq_tdata, m_axis_rq_tkeep,
               m_axis_rq_tlast, m_axis_rq_tuser
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_axis_rq_tready,
        output s_tready, m_axis_rq_tvalid, m_axis_rq_tdata, m_axis_rq_tkeep,
               m_axis_rq_tlast, m_axis_rq_tuser
    );
endinterface

// File: rtl/s_axis_rq_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting port at or above the
// pointer, wrapping to the lowest requester when none is found above it.
// Purely combinational so it can sit in front of any registered grant.
module rr_pick #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic                 any,
    output logic [1:0]           winner
);
    logic [NUM_PORTS-1:0] at_or_above;
    logic [NUM_PORTS-1:0] req_hi;
    logic [1:0]           hi_win;
    logic [1:0]           lo_win;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
            assign at_or_above[gi] = (2'(gi) >= ptr);
        end
    endgenerate

    assign req_hi = req & at_or_above;

    // Lowest-index requester in the upper window and overall; upper wins.
    always_comb begin
        hi_win = 2'd0;
        lo_win = 2'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                hi_win = 2'(i);
            end
            if (req[i]) begin
                lo_win = 2'(i);
            end
        end
        any    = |req;
        winner = (|req_hi) ? hi_win : lo_win;
    end

endmodule

// File: rtl/s_axis_rq_arbiter.sv
// Packet-granular round-robin arbiter for the RQ AXIS stream. A grant is
// taken in one idle cycle and held until the granted port's tlast beat is
// accepted. Each port carries a credit counter of outstanding reads; a port
// whose head packet is a read is skipped while its counter is full.
module s_axis_rq_arbiter
    import s_axis_rq_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_NP     = 8
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    s_axis_rq_arbiter_if.slave   rq_bus,
    input  logic [NUM_PORTS-1:0] np_done,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] np_err
);
    localparam int NPW = $clog2(MAX_NP + 1);

    arb_state_t state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic       first_reg, first_next;

    // Per-port views padded to RQ_PORTS_MAX so a 2-bit grant indexes safely.
    logic [RQ_PORTS_MAX-1:0] valid_pad;
    logic [RQ_PORTS_MAX-1:0] last_pad;
    logic [DATA_WIDTH-1:0]   data_pad [RQ_PORTS_MAX];
    logic [KEEP_WIDTH-1:0]   keep_pad [RQ_PORTS_MAX];
    rq_tuser_t               user_pad [RQ_PORTS_MAX];

    logic [NUM_PORTS-1:0] eligible;
    logic                 pick_any;
    logic [1:0]           pick_winner;
    logic                 in_busy;
    logic                 out_valid;
    logic                 beat_accept;

    // Only bit 0 of the adapter's ready is meaningful.
    logic unused_tready;
    assign unused_tready = &{1'b0, rq_bus.m_axis_rq_tready[3:1]};

    genvar gi;
    generate
        for (gi = 0; gi < RQ_PORTS_MAX; gi++) begin : g_pad
            if (gi < NUM_PORTS) begin : g_live
                assign valid_pad[gi] = rq_bus.s_tvalid[gi];
                assign last_pad[gi]  = rq_bus.s_tlast[gi];
                assign data_pad[gi]  = rq_bus.s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
                assign keep_pad[gi]  = rq_bus.s_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
                assign user_pad[gi]  = rq_tuser_t'(rq_bus.s_tuser[gi*4 +: 4]);
            end else begin : g_tie
                assign valid_pad[gi] = 1'b0;
                assign last_pad[gi]  = 1'b0;
                assign data_pad[gi]  = '0;
                assign keep_pad[gi]  = '0;
                assign user_pad[gi]  = '0;
            end
        end
    endgenerate

    // Output path: straight pass-through from the granted port while busy.
    assign in_busy     = (state_reg == ST_BUSY);
    assign out_valid   = in_busy & valid_pad[grant_reg];
    assign beat_accept = out_valid & rq_bus.m_axis_rq_tready[0];

    assign rq_bus.m_axis_rq_tvalid = out_valid;
    assign rq_bus.m_axis_rq_tdata  = data_pad[grant_reg];
    assign rq_bus.m_axis_rq_tkeep  = keep_pad[grant_reg];
    assign rq_bus.m_axis_rq_tlast  = last_pad[grant_reg];
    assign rq_bus.m_axis_rq_tuser  = user_pad[grant_reg];

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign rq_bus.s_tready[gi] = in_busy & (grant_reg == 2'(gi))
                                       & rq_bus.m_axis_rq_tready[0];
        end
    endgenerate

    assign busy     = in_busy;
    assign grant_id = grant_reg;

    // Read credit tracking; a full counter blocks only ports offering a read.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_np
            logic [NPW-1:0] np_cnt_reg;
            logic           np_err_reg;
            logic           head_is_read;
            logic           np_full;
            logic           np_inc;

            assign head_is_read = (data_pad[gi][31:30] == FMT_NODATA);
            assign np_full      = (np_cnt_reg == NPW'(MAX_NP));
            assign eligible[gi] = rq_bus.s_tvalid[gi] & ~(head_is_read & np_full);
            assign np_inc       = beat_accept & first_reg & (grant_reg == 2'(gi))
                                & head_is_read;
            assign np_err[gi]   = np_err_reg;

            // Count reads issued minus reads completed; underflow is flagged.
            always_ff @(posedge user_clk) begin
                if (user_reset) begin
                    np_cnt_reg <= '0;
                    np_err_reg <= 1'b0;
                end else if (np_inc && !np_done[gi]) begin
                    if (!np_full) begin
                        np_cnt_reg <= np_cnt_reg + NPW'(1);
                    end
                end else if (np_done[gi] && !np_inc) begin
                    if (np_cnt_reg == '0) begin
                        np_err_reg <= 1'b1;
                    end else begin
                        np_cnt_reg <= np_cnt_reg - NPW'(1);
                    end
                end
            end
        end
    endgenerate

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req    (eligible),
        .ptr    (rr_ptr_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Arbitration state: grant in IDLE, release after the tlast beat.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        first_next  = first_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_BUSY;
                    grant_next = pick_winner;
                    first_next = 1'b1;
                end
            end
            ST_BUSY: begin
                if (beat_accept) begin
                    first_next = 1'b0;
                    if (last_pad[grant_reg]) begin
                        state_next  = ST_IDLE;
                        rr_ptr_next = rr_next(grant_reg, NUM_PORTS);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset drops any packet in flight immediately.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= 2'd0;
            rr_ptr_reg <= 2'd0;
            first_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            first_reg  <= first_next;
        end
    end

endmodule
